// File: rtl/pc_gen.sv
// pc_gen: fetch-address generator for the IF stage.
// Holds the fetch PC and presents it to instruction SRAM over an if_req/if_addr_ok
// handshake. The PC advances by INC on each accepted request, or jumps to a branch
// or exception target. A redirect that arrives while a request is waiting for
// acceptance goes into a one-deep buffer per kind and is applied at acceptance.
// Each accepted address is reported one cycle later with an alignment-error flag.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   stall                    blocks issue of a new request (not one already presented)
//   br_valid, br_target      branch/jump redirect strobe and target
//   exc_valid, exc_target    exception/ERET redirect strobe and target
//   if_req, if_addr          fetch request and address to SRAM (combinational)
//   if_addr_ok               SRAM accepts the current request
//   issued_valid/pc/adel     registered report of the address accepted last cycle
module pc_gen #(
    parameter int unsigned          ADDR_W     = 32,
    parameter logic [ADDR_W-1:0]    RESET_VEC  = ADDR_W'(32'hbfc0_0000),
    parameter int unsigned          INC        = 4,
    parameter int unsigned          ALIGN_BITS = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              exc_valid,
    input  logic [ADDR_W-1:0] exc_target,
    output logic              if_req,
    output logic [ADDR_W-1:0] if_addr,
    input  logic              if_addr_ok,
    output logic              issued_valid,
    output logic [ADDR_W-1:0] issued_pc,
    output logic              issued_adel
);

    localparam logic [ADDR_W-1:0] INC_V      = ADDR_W'(INC);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = (ADDR_W'(1) << ALIGN_BITS) - ADDR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READY = 2'd1,
        S_REQ   = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc, pc_nxt;
    logic              pend_exc, pend_exc_nxt;
    logic [ADDR_W-1:0] pend_exc_tgt, pend_exc_tgt_nxt;
    logic              pend_br, pend_br_nxt;
    logic [ADDR_W-1:0] pend_br_tgt, pend_br_tgt_nxt;
    logic              accept;

    // Request is held in REQ regardless of stall so an outstanding fetch is never withdrawn.
    always_comb begin
        if_req = (state == S_REQ) || ((state == S_READY) && !stall);
        accept = if_req && if_addr_ok;
    end

    assign if_addr = pc;

    // Next state, next PC and pending-buffer updates.
    always_comb begin
        state_nxt        = state;
        pc_nxt           = pc;
        pend_exc_nxt     = pend_exc;
        pend_exc_tgt_nxt = pend_exc_tgt;
        pend_br_nxt      = pend_br;
        pend_br_tgt_nxt  = pend_br_tgt;

        case (state)
            S_IDLE:  state_nxt = S_READY;
            S_READY: state_nxt = (if_req && !if_addr_ok) ? S_REQ : S_READY;
            S_REQ:   state_nxt = if_addr_ok ? S_READY : S_REQ;
            default: state_nxt = S_IDLE;
        endcase

        if (!if_req) begin
            // Nothing presented: a redirect (live or buffered) can move pc right away.
            if (exc_valid) begin
                pc_nxt = exc_target;
            end else if (br_valid) begin
                pc_nxt = br_target;
            end else if (pend_exc) begin
                pc_nxt = pend_exc_tgt;
            end else if (pend_br) begin
                pc_nxt = pend_br_tgt;
            end
            pend_exc_nxt = 1'b0;
            pend_br_nxt  = 1'b0;
        end else if (!if_addr_ok) begin
            // pc must stay stable while the request waits; park redirects instead.
            if (exc_valid) begin
                pend_exc_nxt     = 1'b1;
                pend_exc_tgt_nxt = exc_target;
            end
            if (br_valid) begin
                pend_br_nxt     = 1'b1;
                pend_br_tgt_nxt = br_target;
            end
        end else begin
            // Accepted: an exception (live or buffered) outranks any branch.
            if (exc_valid) begin
                pc_nxt = exc_target;
            end else if (pend_exc) begin
                pc_nxt = pend_exc_tgt;
            end else if (br_valid) begin
                pc_nxt = br_target;
            end else if (pend_br) begin
                pc_nxt = pend_br_tgt;
            end else begin
                pc_nxt = pc + INC_V;
            end
            pend_exc_nxt = 1'b0;
            pend_br_nxt  = 1'b0;
        end
    end

    // State, PC, pending buffer and issue report registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            pc           <= RESET_VEC;
            pend_exc     <= 1'b0;
            pend_exc_tgt <= '0;
            pend_br      <= 1'b0;
            pend_br_tgt  <= '0;
            issued_valid <= 1'b0;
            issued_pc    <= '0;
            issued_adel  <= 1'b0;
        end else begin
            state        <= state_nxt;
            pc           <= pc_nxt;
            pend_exc     <= pend_exc_nxt;
            pend_exc_tgt <= pend_exc_tgt_nxt;
            pend_br      <= pend_br_nxt;
            pend_br_tgt  <= pend_br_tgt_nxt;
            issued_valid <= accept;
            if (accept) begin
                issued_pc <= pc;
            end
            issued_adel  <= accept && ((pc & ALIGN_MASK) != '0);
        end
    end

endmodule
